// File: rtl/queue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : queue_ctrl_if                                          |
// | Description : Bundle of signals between the queue controller, its    |
// |               two requesters (A, B) and the attached queue.          |
// |   slave  : controller side (takes commands, drives the queue bus).   |
// |   master : environment side (requesters plus the queue itself).      |
// |   Signals                                                            |
// |     a_/b_valid, a_/b_op[2:0], a_/b_data[7:0] : requester command     |
// |     a_/b_ready, a_/b_rsp                     : handshake, strobe     |
// |     rsp_data[7:0], rsp_err                   : shared response       |
// |     q_apply, q_op[2:0], q_in[7:0]            : command to the queue  |
// |     q_first[7:0], q_second[7:0], q_valid     : queue status          |
// |     level[3:0]                               : shadow element count  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface queue_ctrl_if;
   logic       a_valid;
   logic [2:0] a_op;
   logic [7:0] a_data;
   logic       a_ready;
   logic       a_rsp;
   logic       b_valid;
   logic [2:0] b_op;
   logic [7:0] b_data;
   logic       b_ready;
   logic       b_rsp;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       q_apply;
   logic [2:0] q_op;
   logic [7:0] q_in;
   logic [7:0] q_first;
   logic [7:0] q_second;
   logic       q_valid;
   logic [3:0] level;

   modport slave (
      input  a_valid, a_op, a_data, b_valid, b_op, b_data,
      input  q_first, q_second, q_valid,
      output a_ready, a_rsp, b_ready, b_rsp, rsp_data, rsp_err,
      output q_apply, q_op, q_in, level
   );

   modport master (
      output a_valid, a_op, a_data, b_valid, b_op, b_data,
      output q_first, q_second, q_valid,
      input  a_ready, a_rsp, b_ready, b_rsp, rsp_data, rsp_err,
      input  q_apply, q_op, q_in, level
   );
endinterface
`default_nettype wire

// File: rtl/queue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : queue_ctrl                                             |
// | Description : Two-requester command controller for an external       |
// |               8-bit element queue. Round-robin arbitration, one      |
// |               command per three cycles (IDLE -> EXEC -> RESP), a     |
// |               shadow element count and a terminal FAULT state when   |
// |               the queue reports q_valid=0.                           |
// | Parameters  : DEPTH - queue capacity in elements (2..15)             |
// | Ports       : clk  - clock, rising edge                              |
// |               rst  - asynchronous reset, active low                  |
// |               bus  - queue_ctrl_if.slave (requesters, response,      |
// |                      queue command bus, queue status, level)         |
// | Macro       : QUEUE_CTRL_DIV_EN - when defined, ops 5 (div) and 6    |
// |               (mod) are supported; otherwise they are illegal and    |
// |               no divider is built.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module queue_ctrl #(
   parameter int DEPTH = 10
) (
   input wire          clk,
   input wire          rst,
   queue_ctrl_if.slave bus
);

   localparam logic [3:0] c_depth   = 4'(DEPTH);
   localparam logic [2:0] c_op_push = 3'd0;
   localparam logic [2:0] c_op_pop  = 3'd1;
   localparam logic [2:0] c_op_add  = 3'd2;
   localparam logic [2:0] c_op_sub  = 3'd3;
   localparam logic [2:0] c_op_mul  = 3'd4;
`ifdef QUEUE_CTRL_DIV_EN
   localparam logic [2:0] c_op_div  = 3'd5;
   localparam logic [2:0] c_op_mod  = 3'd6;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_RESP  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_last_b;     // 1: B won the last grant, so A wins a tie
   logic       r_sel_b;      // requester owning the in-flight command
   logic [2:0] r_op;
   logic [7:0] r_data;
   logic [3:0] r_level;
   logic [7:0] r_rsp_data;
   logic       r_rsp_err;
   logic       r_fault_rsp;  // a command was cut off by a fault, answer it once

   logic       w_grant_a;
   logic       w_grant_b;
   logic       w_accept;
   logic       w_two;
   logic       w_legal;
   logic [7:0] w_result;
   logic       w_exec_ok;
   logic       w_rsp_now;

   // Readies are gated by q_valid so that nothing is accepted in the
   // cycle the controller is about to fault.
   assign w_grant_a = (r_state == S_IDLE) && bus.q_valid && bus.a_valid &&
                      (!bus.b_valid || r_last_b);
   assign w_grant_b = (r_state == S_IDLE) && bus.q_valid && bus.b_valid &&
                      (!bus.a_valid || !r_last_b);
   assign w_accept  = w_grant_a || w_grant_b;
   assign w_two     = (r_level >= 4'd2);

`ifdef QUEUE_CTRL_DIV_EN
   logic       w_s_nz;
   logic [7:0] w_div_s;
   logic [7:0] w_quot;
   logic [7:0] w_rem;

   // The divisor is forced to 1 when S=0; the command is illegal then
   // and the quotient is never used.
   assign w_s_nz  = (bus.q_second != 8'd0);
   assign w_div_s = w_s_nz ? bus.q_second : 8'd1;
   assign w_quot  = bus.q_first / w_div_s;
   assign w_rem   = bus.q_first % w_div_s;
`endif

   // Legality and result of the latched command against the current level
   // and queue head. Ops 2-6 consume two elements and leave one.
   always_comb begin
      w_legal  = 1'b0;
      w_result = 8'd0;
      case (r_op)
         c_op_push: begin
            w_legal  = (r_level < c_depth);
            w_result = r_data;
         end
         c_op_pop: begin
            w_legal  = (r_level != 4'd0);
            w_result = bus.q_first;
         end
         c_op_add: begin
            w_legal  = w_two;
            w_result = bus.q_first + bus.q_second;
         end
         c_op_sub: begin
            w_legal  = w_two;
            w_result = bus.q_first - bus.q_second;
         end
         c_op_mul: begin
            w_legal  = w_two;
            w_result = bus.q_first * bus.q_second;
         end
`ifdef QUEUE_CTRL_DIV_EN
         c_op_div: begin
            w_legal  = w_two && w_s_nz;
            w_result = w_quot;
         end
         c_op_mod: begin
            w_legal  = w_two && w_s_nz;
            w_result = w_rem;
         end
`endif
         default: begin
            w_legal  = 1'b0;
            w_result = 8'd0;
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!bus.q_valid)  w_state_nxt = S_FAULT;
            else if (w_accept) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (!bus.q_valid) w_state_nxt = S_FAULT;
            else              w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (!bus.q_valid) w_state_nxt = S_FAULT;
            else              w_state_nxt = S_IDLE;
         end
         S_FAULT: w_state_nxt = S_FAULT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_exec_ok    = (r_state == S_EXEC) && bus.q_valid;
   assign w_rsp_now    = (r_state == S_RESP) || ((r_state == S_FAULT) && r_fault_rsp);

   assign bus.a_ready  = w_grant_a;
   assign bus.b_ready  = w_grant_b;
   assign bus.q_apply  = w_exec_ok && w_legal;
   assign bus.q_op     = bus.q_apply ? r_op : 3'd0;
   assign bus.q_in     = bus.q_apply ? w_result : 8'd0;
   assign bus.a_rsp    = w_rsp_now && !r_sel_b;
   assign bus.b_rsp    = w_rsp_now && r_sel_b;
   assign bus.rsp_data = r_rsp_data;
   assign bus.rsp_err  = r_rsp_err;
   assign bus.level    = r_level;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_last_b    <= 1'b1;
         r_sel_b     <= 1'b0;
         r_op        <= 3'd0;
         r_data      <= 8'd0;
         r_level     <= 4'd0;
         r_rsp_data  <= 8'd0;
         r_rsp_err   <= 1'b0;
         r_fault_rsp <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            r_sel_b  <= w_grant_b;
            r_last_b <= w_grant_b;
            r_op     <= w_grant_b ? bus.b_op   : bus.a_op;
            r_data   <= w_grant_b ? bus.b_data : bus.a_data;
         end

         if (r_state == S_EXEC) begin
            if (!bus.q_valid) begin
               r_rsp_data  <= 8'd0;
               r_rsp_err   <= 1'b1;
               r_fault_rsp <= 1'b1;
            end else if (w_legal) begin
               r_rsp_data <= w_result;
               r_rsp_err  <= 1'b0;
               if (r_op == c_op_push) r_level <= r_level + 4'd1;
               else                   r_level <= r_level - 4'd1;
            end else begin
               r_rsp_data <= 8'd0;
               r_rsp_err  <= 1'b1;
            end
         end

         if (r_state == S_FAULT) begin
            r_fault_rsp <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_queue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_queue_ctrl                                          |
// | Description : Self-checking bench for queue_ctrl. Holds a simple     |
// |               queue device (env_q) driven by the DUT command bus,    |
// |               and an independent reference model (ref_q) computed    |
// |               from the command rules. Directed cases followed by     |
// |               randomized traffic.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_queue_ctrl;
   localparam int DEPTH = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   queue_ctrl_if ifc ();

   queue_ctrl #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] env_q[$];
   logic [7:0] ref_q[$];
   bit         last_b_m = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_status();
      ifc.q_first  = (env_q.size() > 0) ? env_q[0] : 8'd0;
      ifc.q_second = (env_q.size() > 1) ? env_q[1] : 8'd0;
   endtask

   // The attached queue: FIFO, front element is F, next is S; a two-operand
   // op removes F and S and puts its result at the front.
   task automatic env_apply(input logic [2:0] op, input logic [7:0] din);
      if (op == 3'd0) env_q.push_back(din);
      else if (op == 3'd1) void'(env_q.pop_front());
      else begin
         void'(env_q.pop_front());
         void'(env_q.pop_front());
         env_q.push_front(din);
      end
      drive_status();
   endtask

   // Reference model: legality and result from the command rules, plain
   // integer arithmetic reduced modulo 256.
   task automatic model(input logic [2:0] op, input logic [7:0] d,
                        output bit legal, output logic [7:0] res);
      int n = ref_q.size();
      int f = (n > 0) ? int'(ref_q[0]) : 0;
      int s = (n > 1) ? int'(ref_q[1]) : 0;
      int r = 0;
      legal = 1'b0;
      case (op)
         3'd0: begin legal = (n < DEPTH); r = int'(d); end
         3'd1: begin legal = (n >= 1);    r = f; end
         3'd2: begin legal = (n >= 2);    r = (f + s) % 256; end
         3'd3: begin legal = (n >= 2);    r = (f - s + 256) % 256; end
         3'd4: begin legal = (n >= 2);    r = (f * s) % 256; end
`ifdef QUEUE_CTRL_DIV_EN
         3'd5: begin legal = (n >= 2) && (s != 0); r = (s != 0) ? f / s : 0; end
         3'd6: begin legal = (n >= 2) && (s != 0); r = (s != 0) ? f % s : 0; end
`endif
         default: legal = 1'b0;
      endcase
      if (!legal) r = 0;
      res = 8'(r);
      if (legal) begin
         if (op == 3'd0) ref_q.push_back(res);
         else if (op == 3'd1) void'(ref_q.pop_front());
         else begin
            void'(ref_q.pop_front());
            void'(ref_q.pop_front());
            ref_q.push_front(res);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ifc.a_valid = 1'b0; ifc.a_op = 3'd0; ifc.a_data = 8'd0;
      ifc.b_valid = 1'b0; ifc.b_op = 3'd0; ifc.b_data = 8'd0;
      ifc.q_valid = 1'b1;
      env_q.delete();
      ref_q.delete();
      drive_status();
      last_b_m = 1'b1;
      @(negedge clk);
      chk("rst_level",    32'(ifc.level), 32'd0);
      chk("rst_q_apply",  32'(ifc.q_apply), 32'd0);
      chk("rst_q_op_in",  32'({ifc.q_op, ifc.q_in}), 32'd0);
      chk("rst_rsp",      32'({ifc.a_rsp, ifc.b_rsp}), 32'd0);
      chk("rst_rsp_data", 32'(ifc.rsp_data), 32'd0);
      chk("rst_rsp_err",  32'(ifc.rsp_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // One complete command. Entered and left at posedge+1 with DUT idle.
   task automatic run_cmd(input bit av, input logic [2:0] aop, input logic [7:0] ad,
                          input bit bv, input logic [2:0] bop, input logic [7:0] bd);
      bit         exp_b;
      bit         legal;
      logic [7:0] res;
      logic [2:0] op;
      logic [7:0] d;
      bit         app;
      logic [2:0] app_op;
      logic [7:0] app_in;
      ifc.a_valid = av; ifc.a_op = aop; ifc.a_data = ad;
      ifc.b_valid = bv; ifc.b_op = bop; ifc.b_data = bd;
      exp_b = (av && bv) ? !last_b_m : bv;
      @(negedge clk);
      chk("a_ready", 32'(ifc.a_ready), 32'(!exp_b));
      chk("b_ready", 32'(ifc.b_ready), 32'(exp_b));
      last_b_m = exp_b;
      op = exp_b ? bop : aop;
      d  = exp_b ? bd  : ad;
      model(op, d, legal, res);
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_ready", 32'({ifc.a_ready, ifc.b_ready}), 32'd0);
      chk("q_apply", 32'(ifc.q_apply), 32'(legal));
      if (legal) begin
         chk("q_op", 32'(ifc.q_op), 32'(op));
         if (op != 3'd1) chk("q_in", 32'(ifc.q_in), 32'(res));
      end
      app = ifc.q_apply; app_op = ifc.q_op; app_in = ifc.q_in;
      @(posedge clk); #1;
      if (app) env_apply(app_op, app_in);
      @(negedge clk);
      chk("q_apply_resp", 32'(ifc.q_apply), 32'd0);
      chk("a_rsp", 32'(ifc.a_rsp), 32'(!exp_b));
      chk("b_rsp", 32'(ifc.b_rsp), 32'(exp_b));
      chk("rsp_err", 32'(ifc.rsp_err), 32'(!legal));
      chk("rsp_data", 32'(ifc.rsp_data), 32'(res));
      chk("level", 32'(ifc.level), 32'(ref_q.size()));
      @(posedge clk); #1;
      chk("rsp_pulse_end", 32'({ifc.a_rsp, ifc.b_rsp}), 32'd0);
   endtask

   task automatic cmd_a(input logic [2:0] op, input logic [7:0] d);
      run_cmd(1'b1, op, d, 1'b0, 3'd0, 8'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         av, bv;
      logic [2:0] aop, bop;
      do_reset();

      // push 7, push 3, sub -> 4, level 1
      cmd_a(3'd0, 8'd7);
      cmd_a(3'd0, 8'd3);
      cmd_a(3'd3, 8'd0);
      chk("sub_7_3", 32'(ifc.rsp_data), 32'd4);
      chk("sub_level", 32'(ifc.level), 32'd1);

      // arbitration: A wins first tie after reset, then alternation
      do_reset();
      run_cmd(1'b1, 3'd0, 8'd1, 1'b1, 3'd0, 8'd2);
      chk("first_tie_a", 32'(ifc.rsp_data), 32'd1);
      for (int i = 0; i < 4; i++) run_cmd(1'b1, 3'd0, 8'(10 + i), 1'b1, 3'd0, 8'(20 + i));
      run_cmd(1'b0, 3'd1, 8'd0, 1'b1, 3'd1, 8'd0);
      run_cmd(1'b1, 3'd1, 8'd0, 1'b0, 3'd1, 8'd0);

      // overflow and underflow
      do_reset();
      for (int i = 0; i < 10; i++) cmd_a(3'd0, 8'(i + 1));
      cmd_a(3'd0, 8'd99);
      chk("overflow_err", 32'(ifc.rsp_err), 32'd1);
      chk("overflow_level", 32'(ifc.level), 32'd10);
      do_reset();
      cmd_a(3'd1, 8'd0);
      chk("underflow_err", 32'(ifc.rsp_err), 32'd1);

      // div / mod
      do_reset();
      cmd_a(3'd0, 8'd9); cmd_a(3'd0, 8'd0); cmd_a(3'd5, 8'd0);
      chk("div_by_zero_err", 32'(ifc.rsp_err), 32'd1);
      do_reset();
      cmd_a(3'd0, 8'd9); cmd_a(3'd0, 8'd2); cmd_a(3'd6, 8'd0);
`ifdef QUEUE_CTRL_DIV_EN
      chk("mod_9_2", 32'(ifc.rsp_data), 32'd1);
`else
      chk("mod_disabled_err", 32'(ifc.rsp_err), 32'd1);
`endif

      // wrap-around arithmetic
      do_reset();
      cmd_a(3'd0, 8'd200); cmd_a(3'd0, 8'd100); cmd_a(3'd2, 8'd0);
      chk("add_wrap", 32'(ifc.rsp_data), 32'd44);
      do_reset();
      cmd_a(3'd0, 8'd16); cmd_a(3'd0, 8'd16); cmd_a(3'd4, 8'd0);
      chk("mul_wrap", 32'(ifc.rsp_data), 32'd0);
      cmd_a(3'd7, 8'd0);
      chk("op7_err", 32'(ifc.rsp_err), 32'd1);

      // fault while idle: readies stay low, exit only via reset
      do_reset();
      cmd_a(3'd0, 8'd1);
      ifc.q_valid = 1'b0;
      ifc.a_valid = 1'b1; ifc.a_op = 3'd0; ifc.a_data = 8'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("fault_ready", 32'({ifc.a_ready, ifc.b_ready}), 32'd0);
         chk("fault_apply", 32'(ifc.q_apply), 32'd0);
      end
      ifc.q_valid = 1'b1;
      @(negedge clk);
      chk("fault_sticky", 32'({ifc.a_ready, ifc.b_ready}), 32'd0);
      @(posedge clk); #1;
      do_reset();
      chk("post_fault_level", 32'(ifc.level), 32'd0);
      cmd_a(3'd0, 8'd5);

      // fault while executing: one error response, then silence
      do_reset();
      cmd_a(3'd0, 8'd1);
      ifc.a_valid = 1'b1; ifc.a_op = 3'd0; ifc.a_data = 8'd2;
      @(negedge clk);
      chk("fx_ready", 32'(ifc.a_ready), 32'd1);
      @(posedge clk); #1;
      ifc.a_valid = 1'b0;
      ifc.q_valid = 1'b0;
      @(negedge clk);
      chk("fx_apply", 32'(ifc.q_apply), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fx_rsp", 32'(ifc.a_rsp), 32'd1);
      chk("fx_err", 32'(ifc.rsp_err), 32'd1);
      chk("fx_data", 32'(ifc.rsp_data), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fx_rsp_once", 32'({ifc.a_rsp, ifc.b_rsp}), 32'd0);
      chk("fx_level", 32'(ifc.level), 32'd1);
      @(posedge clk); #1;

      // reset in EXEC drops q_apply at once, no response afterwards
      do_reset();
      ifc.a_valid = 1'b1; ifc.a_op = 3'd0; ifc.a_data = 8'd5;
      @(negedge clk);
      @(posedge clk); #1;
      ifc.a_valid = 1'b0;
      @(negedge clk);
      chk("rx_apply", 32'(ifc.q_apply), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("rx_async_drop", 32'(ifc.q_apply), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rx_no_rsp", 32'({ifc.a_rsp, ifc.b_rsp}), 32'd0);
         chk("rx_level", 32'(ifc.level), 32'd0);
      end
      @(posedge clk); #1;

      // randomized traffic
      do_reset();
      for (int i = 0; i < 300; i++) begin
         av = 1'($urandom % 2);
         bv = 1'($urandom % 2);
         if (!av && !bv) av = 1'b1;
         aop = ($urandom % 10 < 4) ? 3'd0 : 3'($urandom_range(1, 7));
         bop = ($urandom % 10 < 4) ? 3'd0 : 3'($urandom_range(1, 7));
         run_cmd(av, aop, ($urandom % 4 == 0) ? 8'd0 : 8'($urandom),
                 bv, bop, ($urandom % 4 == 0) ? 8'd0 : 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
